// File: rtl/tft_spi_ctrl.sv
// TFT SPI front-end controller: panel hardware-reset sequencing, command/pixel
// arbitration and a single-word output slot toward the SPI word serializer.
module tft_spi_ctrl #(
   parameter int RST_LOW_CYCLES  = 1000,
   parameter int RST_WAIT_CYCLES = 5000,
   parameter int BURST_MAX       = 64,
   parameter int CNT_W           = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [15:0] cmd_data,
   input  logic        cmd_dc,
   output logic        cmd_ready,
   input  logic        pix_valid,
   input  logic [15:0] pix_data,
   output logic        pix_ready,
   output logic [15:0] ser_word,
   output logic        ser_dc,
   output logic        ser_valid,
   input  logic        ser_ready,
   output logic        tft_rst_n,
   output logic        init_done,
   output logic        busy
);

   localparam int BW = $clog2(BURST_MAX + 1);

   typedef enum logic [2:0] {
      ST_RST_LOW,
      ST_RST_WAIT,
      ST_IDLE,
      ST_CMD,
      ST_PIX
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [BW-1:0]    burst_cnt;
   logic             space;
   logic             cmd_acc;
   logic             pix_acc;

   // The slot is free when empty or when its word leaves on this edge.
   assign space     = !ser_valid || ser_ready;
   assign cmd_ready = (state == ST_CMD) && space;
   assign pix_ready = (state == ST_PIX) && space && (burst_cnt < BW'(BURST_MAX));
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign pix_acc   = pix_valid && pix_ready;
   assign busy      = (state == ST_CMD) || (state == ST_PIX) || ser_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RST_LOW;
         cnt       <= '0;
         burst_cnt <= '0;
         tft_rst_n <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_RST_LOW: begin
               if (cnt == CNT_W'(RST_LOW_CYCLES - 1)) begin
                  state     <= ST_RST_WAIT;
                  cnt       <= '0;
                  tft_rst_n <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RST_WAIT: begin
               if (cnt == CNT_W'(RST_WAIT_CYCLES - 1)) begin
                  state     <= ST_IDLE;
                  cnt       <= '0;
                  init_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (cmd_valid) begin
                  state <= ST_CMD;
               end else if (pix_valid) begin
                  state     <= ST_PIX;
                  burst_cnt <= '0;
               end
            end
            ST_CMD: begin
               if (!cmd_valid)
                  state <= ST_IDLE;
            end
            ST_PIX: begin
               if (pix_acc)
                  burst_cnt <= burst_cnt + 1'b1;
               if (!pix_valid)
                  state <= ST_IDLE;
               else if (pix_acc && (burst_cnt == BW'(BURST_MAX - 1)))
                  state <= ST_IDLE;
            end
            default: state <= ST_RST_LOW;
         endcase
      end
   end

   // Output slot: load on accept, otherwise drain when the serializer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ser_word  <= '0;
         ser_dc    <= 1'b0;
         ser_valid <= 1'b0;
      end else if (cmd_acc) begin
         ser_word  <= cmd_data;
         ser_dc    <= cmd_dc;
         ser_valid <= 1'b1;
      end else if (pix_acc) begin
         ser_word  <= pix_data;
         ser_dc    <= 1'b1;
         ser_valid <= 1'b1;
      end else if (ser_ready) begin
         ser_valid <= 1'b0;
      end
   end

endmodule
